// File: rtl/aibcr3_txdig_pkg.sv
// Shared definitions for the TX digital sequencer: state and weak-pull encodings,
// the serialization ratio and the weak-pull decode helper.
package aibcr3_txdig_pkg;

    localparam int SER_RATIO = 4;

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_PARK  = 2'b01,
        ST_ON    = 2'b10,
        ST_DRAIN = 2'b11
    } tx_state_t;

    localparam logic [1:0] WEAK_NONE = 2'b00;
    localparam logic [1:0] WEAK_PU   = 2'b01;
    localparam logic [1:0] WEAK_PD   = 2'b10;

    typedef struct packed {
        logic pulldownen;
        logic pullupenb;
    } weak_pull_t;

    localparam weak_pull_t WEAK_IDLE = '{pulldownen: 1'b0, pullupenb: 1'b1};

    // Code 11 is deliberately treated like "none".
    function automatic weak_pull_t weak_decode(input logic [1:0] mode);
        weak_pull_t w;
        w = WEAK_IDLE;
        case (mode)
            WEAK_PU: w.pullupenb  = 1'b0;
            WEAK_PD: w.pulldownen = 1'b1;
            default: ;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aibcr3_txdig_fifo.sv
// Small word FIFO with a registered head-of-queue output and a registered
// not-full ready flag; a word written this cycle is never visible to a pop this cycle.
module aibcr3_txdig_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wdata,
    input  logic             wvalid,
    output logic             wready,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head_reg;
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             wready_reg;
    logic             push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign push   = wvalid && wready_reg;
    assign do_pop = pop && (count_reg != '0);

    always_comb begin
        rd_ptr_next = do_pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        count_next  = count_reg;
        if (push && !do_pop)
            count_next = count_reg + CW'(1);
        else if (!push && do_pop)
            count_next = count_reg - CW'(1);
    end

    // Storage and registered read; forward the incoming word when it becomes the head.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= wdata;
        if (push && (wr_ptr_reg == rd_ptr_next))
            head_reg <= wdata;
        else
            head_reg <= mem[rd_ptr_next];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            wready_reg <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            wready_reg <= (count_next != CW'(DEPTH));
        end
    end

    assign wready = wready_reg;
    assign empty  = (count_reg == '0);
    assign head   = head_reg;

endmodule

// File: rtl/aibcr3_txdig_seq.sv
// TX digital sequencer: pad park / enable FSM, drive-strength latching,
// weak-pull control and a 4:1 serializer fed from a small word FIFO.
module aibcr3_txdig_seq
    import aibcr3_txdig_pkg::*;
#(
    parameter int PARK_CYC   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_req,
    input  logic [SER_RATIO-1:0] wdata,
    input  logic                 wvalid,
    output logic                 wready,
    input  logic [1:0]           pdrv_cfg,
    input  logic [1:0]           ndrv_cfg,
    input  logic [1:0]           weak_mode,
    output logic                 din,
    output logic                 itx_en_buf,
    output logic [1:0]           ipdrv_buf,
    output logic [1:0]           indrv_buf,
    output logic                 weak_pulldownen,
    output logic                 weak_pullupenb,
    output logic [1:0]           tx_state,
    output logic                 underflow
);
    localparam int         BIT_W     = $clog2(SER_RATIO);
    localparam logic [3:0] PARK_LAST = 4'(PARK_CYC - 1);

    tx_state_t            state_reg;
    logic [3:0]           park_cnt_reg;
    logic [BIT_W-1:0]     bit_cnt_reg;
    logic [SER_RATIO-2:0] shift_reg;
    logic                 din_reg, itx_en_reg, underflow_reg;
    logic [1:0]           ipdrv_reg, indrv_reg;
    weak_pull_t           weak_reg;

    logic                 fifo_empty, active, load, pop;
    logic [SER_RATIO-1:0] fifo_head, load_word;

    assign active    = (state_reg == ST_ON) || (state_reg == ST_DRAIN);
    assign load      = active && (bit_cnt_reg == '0);
    assign pop       = load && !fifo_empty;
    assign load_word = fifo_empty ? '0 : fifo_head;

    aibcr3_txdig_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SER_RATIO)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wdata  (wdata),
        .wvalid (wvalid),
        .wready (wready),
        .pop    (pop),
        .empty  (fifo_empty),
        .head   (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_OFF;
            park_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            din_reg       <= 1'b0;
            itx_en_reg    <= 1'b0;
            ipdrv_reg     <= 2'b00;
            indrv_reg     <= 2'b00;
            weak_reg      <= WEAK_IDLE;
            underflow_reg <= 1'b0;
        end else begin
            underflow_reg <= 1'b0;
            case (state_reg)
                ST_OFF: begin
                    din_reg      <= 1'b0;
                    shift_reg    <= '0;
                    bit_cnt_reg  <= '0;
                    park_cnt_reg <= '0;
                    itx_en_reg   <= 1'b0;
                    weak_reg     <= weak_decode(weak_mode);
                    if (tx_req) begin
                        state_reg <= ST_PARK;
                        ipdrv_reg <= pdrv_cfg;
                        indrv_reg <= ndrv_cfg;
                    end
                end
                ST_PARK: begin
                    din_reg     <= 1'b0;
                    shift_reg   <= '0;
                    bit_cnt_reg <= '0;
                    if (!tx_req) begin
                        state_reg    <= ST_OFF;
                        park_cnt_reg <= '0;
                        itx_en_reg   <= 1'b0;
                        weak_reg     <= weak_decode(weak_mode);
                    end else if (park_cnt_reg == PARK_LAST) begin
                        state_reg    <= ST_ON;
                        park_cnt_reg <= '0;
                        itx_en_reg   <= 1'b1;
                        weak_reg     <= WEAK_IDLE;
                    end else begin
                        park_cnt_reg <= park_cnt_reg + 4'd1;
                        itx_en_reg   <= 1'b0;
                        weak_reg     <= weak_decode(weak_mode);
                    end
                end
                default: begin
                    bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                    // A live request wins over draining, so a reasserted request
                    // at an empty load keeps the link up and reports underflow.
                    if (load && (state_reg == ST_DRAIN) && !tx_req && fifo_empty) begin
                        state_reg   <= ST_OFF;
                        bit_cnt_reg <= '0;
                        shift_reg   <= '0;
                        din_reg     <= 1'b0;
                        itx_en_reg  <= 1'b0;
                        weak_reg    <= weak_decode(weak_mode);
                    end else begin
                        state_reg  <= tx_req ? ST_ON : ST_DRAIN;
                        itx_en_reg <= 1'b1;
                        weak_reg   <= WEAK_IDLE;
                        if (load) begin
                            din_reg       <= load_word[0];
                            shift_reg     <= load_word[SER_RATIO-1:1];
                            underflow_reg <= fifo_empty;
                        end else begin
                            din_reg   <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end
            endcase
        end
    end

    assign din             = din_reg;
    assign itx_en_buf      = itx_en_reg;
    assign ipdrv_buf       = ipdrv_reg;
    assign indrv_buf       = indrv_reg;
    assign weak_pulldownen = weak_reg.pulldownen;
    assign weak_pullupenb  = weak_reg.pullupenb;
    assign tx_state        = state_reg;
    assign underflow       = underflow_reg;

endmodule

// File: tb/tb_aibcr3_txdig_seq.sv
// Directed scenarios followed by random traffic, all outputs compared every cycle
// against a queue-based behavioural model of the sequencer.
module tb_aibcr3_txdig_seq;

    localparam int PARK_CYC = 4;
    localparam int DEPTH    = 4;

    logic       clk = 1'b0;
    logic       rst, tx_req, wvalid;
    logic [3:0] wdata;
    logic [1:0] pdrv_cfg, ndrv_cfg, weak_mode;
    logic       wready, din, itx_en_buf, weak_pulldownen, weak_pullupenb, underflow;
    logic [1:0] ipdrv_buf, indrv_buf, tx_state;

    int n_chk = 0;
    int n_err = 0;

    // model state: mode 0=OFF 1=PARK 2=ON 3=DRAIN
    int         m_mode, m_park, m_phase;
    logic [3:0] m_q[$];
    bit         m_bits[$];
    logic       e_din, e_en, e_pd, e_pub, e_uf, e_wready;
    logic [1:0] e_pdrv, e_ndrv, e_state;

    logic [7:0] seq;
    logic       acc_or, acc_and;
    logic [3:0] fw [5];

    aibcr3_txdig_seq #(
        .PARK_CYC   (PARK_CYC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .tx_req          (tx_req),
        .wdata           (wdata),
        .wvalid          (wvalid),
        .wready          (wready),
        .pdrv_cfg        (pdrv_cfg),
        .ndrv_cfg        (ndrv_cfg),
        .weak_mode       (weak_mode),
        .din             (din),
        .itx_en_buf      (itx_en_buf),
        .ipdrv_buf       (ipdrv_buf),
        .indrv_buf       (indrv_buf),
        .weak_pulldownen (weak_pulldownen),
        .weak_pullupenb  (weak_pullupenb),
        .tx_state        (tx_state),
        .underflow       (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Predicts the outputs that follow the coming clock edge from the present inputs.
    task automatic model_step();
        logic [3:0] w;
        int         nm;
        bit         load;
        if (rst) begin
            m_mode = 0; m_park = 0; m_phase = 0;
            m_q.delete(); m_bits.delete();
            e_din = 0; e_en = 0; e_pdrv = 0; e_ndrv = 0; e_pd = 0; e_pub = 1;
            e_state = 0; e_uf = 0; e_wready = 0;
            return;
        end
        e_uf = 0;
        nm = m_mode;
        if (m_mode == 0) begin
            if (tx_req) begin
                nm = 1; m_park = 0; e_pdrv = pdrv_cfg; e_ndrv = ndrv_cfg;
            end
        end else if (m_mode == 1) begin
            m_park++;
            if (!tx_req) nm = 0;
            else if (m_park == PARK_CYC) begin nm = 2; m_phase = 0; end
        end else begin
            load = (m_phase % 4) == 0;
            m_phase++;
            if (load && m_mode == 3 && !tx_req && m_q.size() == 0) nm = 0;
            else begin
                nm = tx_req ? 2 : 3;
                if (load) begin
                    if (m_q.size() == 0) begin w = 4'h0; e_uf = 1; end
                    else w = m_q.pop_front();
                    for (int k = 0; k < 4; k++) m_bits.push_back(w[k]);
                end
            end
        end
        if (wvalid && e_wready) begin
            m_q.push_back(wdata);
            $display("[%0t] write 0x%h queued, depth %0d", $time, wdata, m_q.size());
        end
        e_wready = (m_q.size() < DEPTH);
        if (nm >= 2) begin
            if (m_bits.size() > 0) e_din = m_bits.pop_front();
            else e_din = 0;
            e_en = 1; e_pd = 0; e_pub = 1;
        end else begin
            m_bits.delete();
            e_din = 0; e_en = 0;
            e_pd  = (weak_mode == 2'b10);
            e_pub = (weak_mode != 2'b01);
        end
        e_state = 2'(nm);
        m_mode = nm;
    endtask

    task automatic check_all();
        chk("din", {7'd0, din}, {7'd0, e_din});
        chk("itx_en_buf", {7'd0, itx_en_buf}, {7'd0, e_en});
        chk("ipdrv_buf", {6'd0, ipdrv_buf}, {6'd0, e_pdrv});
        chk("indrv_buf", {6'd0, indrv_buf}, {6'd0, e_ndrv});
        chk("weak_pulldownen", {7'd0, weak_pulldownen}, {7'd0, e_pd});
        chk("weak_pullupenb", {7'd0, weak_pullupenb}, {7'd0, e_pub});
        chk("tx_state", {6'd0, tx_state}, {6'd0, e_state});
        chk("underflow", {7'd0, underflow}, {7'd0, e_uf});
        chk("wready", {7'd0, wready}, {7'd0, e_wready});
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        fw[0] = 4'h1; fw[1] = 4'h2; fw[2] = 4'h4; fw[3] = 4'h8; fw[4] = 4'hF;
        rst = 1; tx_req = 0; wvalid = 0; wdata = 0;
        pdrv_cfg = 0; ndrv_cfg = 0; weak_mode = 0;
        cyc(); cyc();
        chk("rst_wready", {7'd0, wready}, 8'd0);
        chk("rst_pullupenb", {7'd0, weak_pullupenb}, 8'd1);
        rst = 0;
        cyc();
        chk("wready_after_rst", {7'd0, wready}, 8'd1);

        // queue 0xA, 0x3 while OFF
        wvalid = 1; wdata = 4'hA; cyc();
        wdata = 4'h3; cyc();
        wvalid = 0;

        // park sequence, tx_req rises in cycle 0
        tx_req = 1; pdrv_cfg = 2'b10; ndrv_cfg = 2'b01; weak_mode = 2'b01;
        cyc();
        for (int i = 1; i <= 4; i++) begin
            chk("park_state", {6'd0, tx_state}, 8'h01);
            chk("park_pullupenb", {7'd0, weak_pullupenb}, 8'd0);
            chk("park_en", {7'd0, itx_en_buf}, 8'd0);
            cyc();
        end
        chk("on_en", {7'd0, itx_en_buf}, 8'd1);
        chk("on_pullupenb", {7'd0, weak_pullupenb}, 8'd1);
        chk("on_state", {6'd0, tx_state}, 8'h02);

        // drive config changes while ON, then collect din for cycles L+1..L+8
        pdrv_cfg = 2'b11; ndrv_cfg = 2'b00;
        cyc();
        acc_or = 0;
        for (int i = 0; i < 8; i++) begin seq[i] = din; acc_or |= underflow; cyc(); end
        chk("data_order", seq, 8'h3A);
        chk("data_no_underflow", {7'd0, acc_or}, 8'd0);
        chk("ipdrv_hold", {6'd0, ipdrv_buf}, 8'h02);
        chk("indrv_hold", {6'd0, indrv_buf}, 8'h01);

        // empty FIFO while ON: one underflow pulse per load, din stays low
        acc_or = 0;
        for (int i = 0; i < 8; i++) begin seq[i] = underflow; acc_or |= din; cyc(); end
        chk("underflow_pattern", seq, 8'h11);
        chk("underflow_din_low", {7'd0, acc_or}, 8'd0);

        // short DRAIN then reassert: cadence must continue without a gap
        tx_req = 0; cyc();
        chk("drain_state", {6'd0, tx_state}, 8'h03);
        tx_req = 1; cyc();
        chk("reassert_state", {6'd0, tx_state}, 8'h02);
        chk("reassert_en", {7'd0, itx_en_buf}, 8'd1);
        run(2);
        chk("reassert_cadence", {7'd0, underflow}, 8'd1);

        // drain with two words queued
        wvalid = 1; wdata = 4'h6; cyc();
        wdata = 4'h9; tx_req = 0; cyc();
        wvalid = 0;
        chk("drain_entry", {6'd0, tx_state}, 8'h03);
        run(2);
        acc_and = 1;
        for (int i = 0; i < 8; i++) begin seq[i] = din; acc_and &= itx_en_buf; cyc(); end
        chk("drain_data", seq, 8'h96);
        chk("drain_en_held", {7'd0, acc_and}, 8'd1);
        chk("drain_off_state", {6'd0, tx_state}, 8'h00);
        chk("drain_off_en", {7'd0, itx_en_buf}, 8'd0);
        chk("drain_off_uf", {7'd0, underflow}, 8'd0);

        // fill the FIFO with five writes and no pops
        wvalid = 1;
        for (int i = 0; i < 5; i++) begin
            wdata = fw[i]; cyc();
            chk("full_wready", {7'd0, wready}, (i < 3) ? 8'd1 : 8'd0);
        end
        wvalid = 0;

        // reset mid-word discards queued and in-flight data
        tx_req = 1; cyc(); run(6);
        rst = 1; cyc();
        chk("midrst_din", {7'd0, din}, 8'd0);
        chk("midrst_en", {7'd0, itx_en_buf}, 8'd0);
        chk("midrst_state", {6'd0, tx_state}, 8'h00);
        chk("midrst_wready", {7'd0, wready}, 8'd0);
        chk("midrst_ipdrv", {6'd0, ipdrv_buf}, 8'h00);
        rst = 0; cyc();
        chk("midrst_wready_after", {7'd0, wready}, 8'd1);
        run(4);
        acc_or = 0;
        for (int i = 0; i < 12; i++) begin acc_or |= din; cyc(); end
        chk("discarded_words", {7'd0, acc_or}, 8'd0);
        tx_req = 0; run(10);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(199) == 0);
            if ($urandom_range(9) == 0) tx_req = ~tx_req;
            wvalid    = ($urandom_range(2) == 0);
            wdata     = 4'($urandom_range(15));
            weak_mode = 2'($urandom_range(3));
            pdrv_cfg  = 2'($urandom_range(3));
            ndrv_cfg  = 2'($urandom_range(3));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
